r_ordering_unit: RTL and testbench
==================================

Name: r_ordering_unit

Overview:
- Sits directly downstream of response_memory.
- Records the issue order of read bursts, as (UID, original ID) pairs, at AR-accept time.
- Selects the UID whose head beat response_memory presents, and streams that burst's beats to the master through a registered output stage with the original ID restored.
- After a burst's last beat, retires the UID and returns it to the UID allocator.
- Release is strictly in global issue order; this is conservative but AXI-legal per-ID ordering.

Parameters:
- NUM_UIDS, 16, number of internal UIDs; also the order FIFO depth.
- MAX_BEATS, 8, maximum beats per burst.
- ID_WIDTH, 4, UID width.
- ORIG_ID_WIDTH, 4, master-side AXI ID width.
- DATA_WIDTH, 64, R data width.
- RESP_WIDTH, 2, R resp width.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  synchronous, active-high reset.
- ord_push_valid  in  1  AR accepted upstream; record the order entry.
- ord_push_ready  out  1  order FIFO not full.
- ord_push_uid  in  ID_WIDTH  UID assigned to the burst.
- ord_push_orig_id  in  ORIG_ID_WIDTH  master's original ARID.
- uid_to_free  out  ID_WIDTH  UID selected in response_memory (head UID).
- rm_valid  in  1  response_memory head beat valid for uid_to_free.
- rm_data  in  DATA_WIDTH  head beat data.
- rm_resp  in  RESP_WIDTH  head beat resp.
- rm_last  in  1  head beat last.
- rm_ready  out  1  pop handshake to response_memory.
- m_r_valid  out  1  R beat to master.
- m_r_id  out  ORIG_ID_WIDTH  restored original ID.
- m_r_data  out  DATA_WIDTH  R data to master.
- m_r_resp  out  RESP_WIDTH  R resp to master.
- m_r_last  out  1  R last to master.
- m_r_ready  in  1  master ready.
- uid_release_valid  out  1  one-cycle pulse; UID retired.
- uid_release  out  ID_WIDTH  retired UID.
- proto_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (synchronous, on rst=1):
  - Order FIFO emptied; pointers and count set to 0.
  - beat_cnt=0; state=IDLE.
  - m_r_valid=0 and m_r_id/data/resp/last=0.
  - uid_release_valid=0, uid_release=0, proto_err=0.
  - rm_ready=0 during reset.
  - Reset mid-burst drops all in-flight state, including the output register, without a release pulse.
- Order FIFO:
  - Circular buffer of NUM_UIDS entries, each {uid, orig_id}.
  - ord_push_ready = (count != NUM_UIDS). No full-bypass: a push while full is refused even if a pop occurs in the same cycle.
  - No empty-bypass: an entry pushed at cycle t is head-visible at t+1.
  - Simultaneous push and pop: count unchanged; both pointers advance; pointers wrap NUM_UIDS-1 -> 0.
- uid_to_free = head.uid when FIFO non-empty, else 0.
- State machine:
  - IDLE: FIFO empty; rm_ready=0. Moves to STREAM when count becomes non-zero.
  - STREAM: rm_ready = ~m_r_valid | m_r_ready. A beat is taken when rm_valid & rm_ready.
  - On beat take:
    - Load the output register with {head.orig_id, rm_data, rm_resp, rm_last}; m_r_valid=1 next cycle.
    - beat_cnt increments.
  - On beat take with rm_last=1:
    - Pop the order FIFO.
    - uid_release_valid=1 and uid_release=head.uid at the next cycle for exactly one cycle.
    - beat_cnt reset to 0.
    - Next state is STREAM if post-pop count is non-zero, else IDLE.
  - The next burst's first beat may be taken in the cycle after the last beat.
- Output register:
  - m_r_valid holds with stable payload until m_r_ready.
  - m_r_valid falls when m_r_ready=1 and no new beat is loaded.
  - Full throughput of one beat per cycle when m_r_ready is held high.
- Latency: a beat taken at cycle t is presented at t+1.
- Error handling:
  - If beat_cnt reaches MAX_BEATS on a beat take with rm_last=0, set proto_err (sticky until reset).
  - The block then forces retirement: m_r_last=1 on that beat, and the pop and release proceed as for a normal last beat.
- rm_valid=1 while the FIFO is empty is ignored (rm_ready=0).
- beat_cnt width is $clog2(MAX_BEATS+1).

Decomposition:
- Shared package r_pkg holds:
  - ID_WIDTH, ORIG_ID_WIDTH, DATA_WIDTH, RESP_WIDTH, NUM_UIDS, MAX_BEATS defaults.
  - typedef ord_entry_t {uid, orig_id}.
  - typedef enum rou_state_t {IDLE, STREAM}.
- One sub-module, order_fifo: a parameterised synchronous circular FIFO of ord_entry_t with push/pop/full/empty/count.
- The FSM, beat counter and output register live in r_ordering_unit.

Test Plan:
1. Single burst.
   - Stimulus: push (uid=3, orig=0xA) at cycle 0; rm presents 4 beats D0..D3 with last on D3; m_r_ready=1.
   - Required: uid_to_free=3 from cycle 1; m_r beats D0..D3 with id=0xA on consecutive cycles, last on D3; one uid_release pulse with uid=3 the cycle after D3 is taken.
2. In-order release.
   - Stimulus: push uid 5 then uid 2; rm holds uid 2's data ready first.
   - Required: uid_to_free stays 5 and nothing is emitted until uid 5's beats arrive; after uid 5 retires, uid_to_free=2.
3. Backpressure.
   - Stimulus: m_r_ready=0 for 3 cycles mid-burst.
   - Required: m_r payload stable; rm_ready=0 while m_r_valid=1 and m_r_ready=0; no beat lost or duplicated.
4. FIFO full/wrap.
   - Stimulus: push 16 entries, then a 17th.
   - Required: 17th refused (ord_push_ready=0); after one retirement the next push is accepted; 20 bursts cycle through wrap with correct uid/orig_id order.
5. Missing last.
   - Stimulus: MAX_BEATS=8 burst with rm_last never set.
   - Required: 8th beat emitted with m_r_last=1; proto_err=1 sticky; UID released.
6. Reset mid-burst.
   - Stimulus: rst=1 after 2 of 4 beats.
   - Required: next cycle m_r_valid=0, ord_push_ready=1, uid_release_valid=0, proto_err=0, state IDLE.

Source files
------------

// File: rtl/r_ordering_unit_pkg.sv
// Shared types and default sizing for the R-channel ordering unit.
// Each burst is tracked as a {uid, orig_id} pair, in issue order.
package r_pkg;

  localparam int DEF_NUM_UIDS      = 16;
  localparam int DEF_MAX_BEATS     = 8;
  localparam int DEF_ID_WIDTH      = 4;
  localparam int DEF_ORIG_ID_WIDTH = 4;
  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_RESP_WIDTH    = 2;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]      uid;
    logic [DEF_ORIG_ID_WIDTH-1:0] orig_id;
  } ord_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rou_state_t;

endpackage

// File: rtl/r_ordering_unit_order_fifo.sv
// Circular FIFO of {uid, orig_id} entries in AR issue order.
// A push is refused while full, even if a pop happens in the same cycle. There is no empty bypass.
module order_fifo
  import r_pkg::*;
#(
  parameter int  DEPTH = DEF_NUM_UIDS,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  ord_entry_t       push_data,
  input  logic             pop,
  output ord_entry_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  ord_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_acc, pop_acc;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;
  assign head     = mem[rd_ptr];

  // Explicit wrap keeps non-power-of-two depths legal.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_acc) - CNT_W'(pop_acc);
    end
  end

endmodule

// File: rtl/r_ordering_unit.sv
// Releases R bursts from response_memory strictly in AR issue order, restores the original ARID,
// and retires each UID back to the allocator after its last beat.
module r_ordering_unit
  import r_pkg::*;
#(
  parameter int NUM_UIDS      = DEF_NUM_UIDS,
  parameter int MAX_BEATS     = DEF_MAX_BEATS,
  parameter int ID_WIDTH      = DEF_ID_WIDTH,
  parameter int ORIG_ID_WIDTH = DEF_ORIG_ID_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int RESP_WIDTH    = DEF_RESP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ord_push_valid,
  output logic                     ord_push_ready,
  input  logic [ID_WIDTH-1:0]      ord_push_uid,
  input  logic [ORIG_ID_WIDTH-1:0] ord_push_orig_id,
  output logic [ID_WIDTH-1:0]      uid_to_free,
  input  logic                     rm_valid,
  input  logic [DATA_WIDTH-1:0]    rm_data,
  input  logic [RESP_WIDTH-1:0]    rm_resp,
  input  logic                     rm_last,
  output logic                     rm_ready,
  output logic                     m_r_valid,
  output logic [ORIG_ID_WIDTH-1:0] m_r_id,
  output logic [DATA_WIDTH-1:0]    m_r_data,
  output logic [RESP_WIDTH-1:0]    m_r_resp,
  output logic                     m_r_last,
  input  logic                     m_r_ready,
  output logic                     uid_release_valid,
  output logic [ID_WIDTH-1:0]      uid_release,
  output logic                     proto_err
);

  localparam int CNT_W  = $clog2(MAX_BEATS + 1);
  localparam int FCNT_W = $clog2(NUM_UIDS + 1);

  rou_state_t        state;
  logic [CNT_W-1:0]  beat_cnt;
  ord_entry_t        head, push_entry;
  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count, post_cnt;
  logic              push_acc, take, cap_hit, eff_last, pop;

  assign push_entry = '{uid: ord_push_uid, orig_id: ord_push_orig_id};

  order_fifo #(.DEPTH(NUM_UIDS)) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ord_push_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ord_push_ready = ~fifo_full;
  assign push_acc       = ord_push_valid & ~fifo_full;
  assign uid_to_free    = fifo_empty ? '0 : head.uid;

  // Take a new beat only when the output register is free or is draining this cycle.
  assign rm_ready = ~rst & (state == STREAM) & ~fifo_empty & (~m_r_valid | m_r_ready);
  assign take     = rm_valid & rm_ready;

  // When a burst reaches MAX_BEATS without rm_last, the final beat is still marked last.
  // This retires the UID so one bad burst cannot wedge the ordering queue.
  assign cap_hit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign eff_last = rm_last | cap_hit;
  assign pop      = take & eff_last;
  assign post_cnt = fifo_count + FCNT_W'(push_acc) - FCNT_W'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      beat_cnt          <= '0;
      m_r_valid         <= 1'b0;
      m_r_id            <= '0;
      m_r_data          <= '0;
      m_r_resp          <= '0;
      m_r_last          <= 1'b0;
      uid_release_valid <= 1'b0;
      uid_release       <= '0;
      proto_err         <= 1'b0;
    end else begin
      uid_release_valid <= pop;
      if (pop) uid_release <= head.uid;

      if (take) begin
        m_r_valid <= 1'b1;
        m_r_id    <= head.orig_id;
        m_r_data  <= rm_data;
        m_r_resp  <= rm_resp;
        m_r_last  <= eff_last;
        beat_cnt  <= pop ? '0 : beat_cnt + 1'b1;
        if (cap_hit && !rm_last) proto_err <= 1'b1;
      end else if (m_r_ready) begin
        m_r_valid <= 1'b0;
      end

      case (state)
        IDLE:    if (fifo_count != '0) state <= STREAM;
        STREAM:  if (pop && post_cnt == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_ordering_unit.sv
// Directed and random stimulus for r_ordering_unit.
// Outputs are checked against a queue-based model of issue-ordered bursts.
module tb_r_ordering_unit;
  import r_pkg::*;

  localparam int NU = DEF_NUM_UIDS;
  localparam int MB = DEF_MAX_BEATS;
  localparam int IW = DEF_ID_WIDTH;
  localparam int OW = DEF_ORIG_ID_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int RW = DEF_RESP_WIDTH;

  typedef struct packed { logic [DW-1:0] data; logic [RW-1:0] resp; logic last; } beat_t;
  typedef struct packed { logic [OW-1:0] id; logic [DW-1:0] data; logic [RW-1:0] resp; logic last; } rbeat_t;
  typedef struct packed { logic [IW-1:0] uid; logic bad; } ord_t;

  logic clk = 1'b0;
  logic rst;
  logic ord_push_valid, ord_push_ready;
  logic [IW-1:0] ord_push_uid, uid_to_free, uid_release;
  logic [OW-1:0] ord_push_orig_id, m_r_id;
  logic rm_valid, rm_last, rm_ready, m_r_valid, m_r_last, m_r_ready;
  logic [DW-1:0] rm_data, m_r_data;
  logic [RW-1:0] rm_resp, m_r_resp;
  logic uid_release_valid, proto_err;

  always #5 clk = ~clk;

  r_ordering_unit dut (
    .clk(clk), .rst(rst),
    .ord_push_valid(ord_push_valid), .ord_push_ready(ord_push_ready),
    .ord_push_uid(ord_push_uid), .ord_push_orig_id(ord_push_orig_id),
    .uid_to_free(uid_to_free),
    .rm_valid(rm_valid), .rm_data(rm_data), .rm_resp(rm_resp), .rm_last(rm_last), .rm_ready(rm_ready),
    .m_r_valid(m_r_valid), .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_r_last(m_r_last), .m_r_ready(m_r_ready),
    .uid_release_valid(uid_release_valid), .uid_release(uid_release), .proto_err(proto_err)
  );

  beat_t  store   [NU][$];  // beats response_memory currently holds per UID
  beat_t  defer_q [NU][$];  // beats withheld until a test releases them
  rbeat_t exp_r[$];         // expected master R stream: bursts in issue order
  ord_t   order_m[$];       // outstanding bursts in issue order
  bit     busy [NU];
  bit     proto_exp, rst_req, push_req, push_acc, push_bad, push_defer, stall_v;
  int     push_nb;
  logic [IW-1:0] push_uid;
  logic [OW-1:0] push_orig;
  rbeat_t stall_val;
  int ready_pct = 100, valid_pct = 100;
  int n_assert, n_fail, cyc, hs_n, hs_first, hs_last, rel_cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_free();
    int s = $urandom_range(NU - 1);
    for (int i = 0; i < NU; i++) if (!busy[(s + i) % NU]) return (s + i) % NU;
    return -1;
  endfunction

  // One clock: drive inputs at negedge, then check settled outputs against the model.
  task automatic tick();
    logic [IW-1:0] h;
    rbeat_t cur;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    ord_push_valid = push_req; ord_push_uid = push_uid; ord_push_orig_id = push_orig;
    m_r_ready = ($urandom_range(99) < ready_pct);
    rm_valid = 1'b0; rm_data = '0; rm_resp = '0; rm_last = 1'b0;
    push_acc = 1'b0;
    if (rst_req) begin stall_v = 1'b0; return; end
    h = uid_to_free;
    if (store[h].size() != 0 && $urandom_range(99) < valid_pct) begin
      rm_valid = 1'b1;
      {rm_data, rm_resp, rm_last} = store[h][0];
    end else if (order_m.size() == 0 && $urandom_range(3) == 0) begin
      rm_valid = 1'b1; rm_data = {$urandom, $urandom}; rm_last = 1'($urandom_range(1));
    end
    #1;
    cur = {m_r_id, m_r_data, m_r_resp, m_r_last};
    if (stall_v && m_r_valid) chk("stall_hold", cur, stall_val);
    stall_v = m_r_valid && !m_r_ready;
    stall_val = cur;
    if (uid_release_valid) begin
      rel_cyc = cyc;
      if (order_m.size() == 0) chk("release_unexpected", 1, 0);
      else begin
        chk("release_uid", uid_release, order_m[0].uid);
        if (order_m[0].bad) proto_exp = 1'b1;
        busy[order_m[0].uid] = 1'b0;
        store[order_m[0].uid].delete();
        void'(order_m.pop_front());
      end
    end
    chk("push_ready", ord_push_ready, order_m.size() != NU);
    chk("uid_to_free", uid_to_free, order_m.size() != 0 ? order_m[0].uid : IW'(0));
    chk("proto_err", proto_err, proto_exp);
    if (m_r_valid && !m_r_ready) chk("rm_ready_stall", rm_ready, 0);
    if (m_r_valid && m_r_ready) begin
      if (hs_n == 0) hs_first = cyc;
      hs_last = cyc;
      hs_n++;
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        chk("r_beat", cur, exp_r[0]);
        void'(exp_r.pop_front());
      end
    end
    if (rm_valid && rm_ready && store[h].size() != 0) void'(store[h].pop_front());
    if (ord_push_valid && ord_push_ready) begin
      push_acc = 1'b1;
      order_m.push_back('{push_uid, push_bad});
      busy[push_uid] = 1'b1;
      for (int i = 0; i < push_nb; i++) begin
        beat_t b;
        b.data = {$urandom, $urandom};
        b.resp = RW'($urandom);
        b.last = (i == push_nb - 1) && !push_bad;
        if (push_defer) defer_q[push_uid].push_back(b);
        else store[push_uid].push_back(b);
        exp_r.push_back('{push_orig, b.data, b.resp, (i == push_nb - 1)});
      end
    end
  endtask

  task automatic push_burst(input logic [IW-1:0] uid, input logic [OW-1:0] orig,
                            input int nb, input bit bad, input bit dfr);
    push_req = 1'b1; push_uid = uid; push_orig = orig;
    push_nb = nb; push_bad = bad; push_defer = dfr;
    tick();
    push_req = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((order_m.size() != 0 || exp_r.size() != 0) && n < limit) begin tick(); n++; end
    chk("drain_done", order_m.size() + exp_r.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    bit bad;
    rst = 1'b1; rst_req = 1'b1; push_req = 1'b0; push_uid = '0; push_orig = '0;
    ord_push_valid = 1'b0; ord_push_uid = '0; ord_push_orig_id = '0;
    rm_valid = 1'b0; rm_data = '0; rm_resp = '0; rm_last = 1'b0; m_r_ready = 1'b0;
    repeat (3) tick();
    rst_req = 1'b0;
    tick();
    chk("rst_m_r_valid", m_r_valid, 0);
    chk("rst_m_r_payload", {m_r_id, m_r_data, m_r_resp, m_r_last}, 0);
    chk("rst_release_valid", uid_release_valid, 0);
    chk("rst_uid_release", uid_release, 0);
    chk("rst_rm_ready", rm_ready, 0);

    // Single 4-beat burst at full throughput.
    hs_n = 0;
    push_burst(4'd3, 4'hA, 4, 1'b0, 1'b0);
    drain(50);
    chk("t1_beats", hs_n, 4);
    chk("t1_back_to_back", hs_last - hs_first, 3);
    chk("t1_release_with_last", rel_cyc, hs_last);

    // A later burst with data ready must wait for the older one.
    hs_n = 0;
    push_burst(4'd5, 4'h1, 3, 1'b0, 1'b1);
    push_burst(4'd2, 4'h2, 2, 1'b0, 1'b0);
    repeat (8) begin
      tick();
      chk("t2_no_emit", m_r_valid, 0);
      chk("t2_head", uid_to_free, 5);
    end
    while (defer_q[5].size() != 0) store[5].push_back(defer_q[5].pop_front());
    drain(100);
    chk("t2_beats", hs_n, 5);

    // Master backpressure mid-burst.
    hs_n = 0;
    push_burst(4'd9, 4'h3, 6, 1'b0, 1'b0);
    for (int k = 0; k < 50 && hs_n < 2; k++) tick();
    ready_pct = 0;
    repeat (3) begin
      tick();
      chk("t3_stall_valid", m_r_valid, 1);
      chk("t3_stall_rm_ready", rm_ready, 0);
    end
    ready_pct = 100;
    drain(100);
    chk("t3_beats", hs_n, 6);

    // Missing last: forced retirement after MAX_BEATS beats.
    hs_n = 0;
    u = pick_free();
    push_burst(IW'(u), 4'hB, MB, 1'b1, 1'b0);
    drain(100);
    chk("t5_beats", hs_n, MB);
    chk("t5_proto_err", proto_err, 1);

    // Fill the order FIFO, refuse the 17th push, then accept one after a retirement.
    valid_pct = 0;
    for (int i = 0; i < NU; i++) push_burst(IW'(i), OW'(i ^ 5), 1 + (i % MB), 1'b0, 1'b0);
    push_burst(4'd0, 4'hF, 2, 1'b0, 1'b0);
    chk("t4_17th_refused", push_acc, 0);
    valid_pct = 100;
    for (int k = 0; k < 100 && order_m.size() == NU; k++) tick();
    u = pick_free();
    push_burst(IW'(u), 4'h7, 2, 1'b0, 1'b0);
    chk("t4_push_after_retire", push_acc, 1);
    drain(500);

    // Random traffic, wrapping the FIFO many times.
    ready_pct = 70; valid_pct = 70;
    for (int it = 0; it < 400; it++) begin
      u = pick_free();
      if (u >= 0 && $urandom_range(99) < 35) begin
        bad = ($urandom_range(19) == 0);
        push_burst(IW'(u), OW'($urandom), bad ? MB : 1 + int'($urandom_range(MB - 1)), bad, 1'b0);
      end else tick();
    end
    ready_pct = 100; valid_pct = 100;
    drain(2000);

    // Reset mid-burst drops everything without a release.
    hs_n = 0;
    push_burst(4'd7, 4'h6, 4, 1'b0, 1'b0);
    for (int k = 0; k < 50 && hs_n < 2; k++) tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    order_m.delete(); exp_r.delete();
    for (int i = 0; i < NU; i++) begin store[i].delete(); busy[i] = 1'b0; end
    proto_exp = 1'b0;
    tick();
    chk("t6_m_r_valid", m_r_valid, 0);
    chk("t6_push_ready", ord_push_ready, 1);
    chk("t6_release_valid", uid_release_valid, 0);
    chk("t6_proto_err", proto_err, 0);
    chk("t6_rm_ready", rm_ready, 0);
    push_burst(4'd7, 4'hC, 2, 1'b0, 1'b0);
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
